// File: rtl/pe_lsb.sv
// LSB-first priority encoder: one-hot grant, inclusive/exclusive upward masks and binary index
// of the lowest asserted request. Purely combinational; CLK and nRST are interface-only.
module pe_lsb #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned USE_ONE_HOT = 1,
    parameter int unsigned USE_COLD    = 1,
    parameter int unsigned USE_INDEX   = 1,
    localparam int unsigned IDX_W      = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] req_vec,
    output logic [WIDTH-1:0] ack_one_hot,
    output logic [WIDTH-1:0] ack_mask,
    output logic [WIDTH-1:0] cold_ack_mask,
    output logic [IDX_W-1:0] ack_index
);

    localparam int unsigned LVLS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_pfx [LVLS+1];
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_cold;
    logic [WIDTH-1:0] w_one_hot;
    logic [IDX_W-1:0] w_index;
    logic             w_unused;

    // Log-depth upward prefix-OR: after level k every bit sees the 2^(k+1) bits at and below it.
    assign w_pfx[0] = req_vec;
    for (genvar k = 0; k < int'(LVLS); k++) begin : g_pfx
        assign w_pfx[k+1] = w_pfx[k] | (w_pfx[k] << (2 ** k));
    end

    assign w_mask    = w_pfx[LVLS];
    assign w_cold    = {w_mask[WIDTH-2:0], 1'b0};
    assign w_one_hot = w_mask & ~w_cold;

    // OR-tree encoder: index bit b collects every one-hot line whose position has bit b set.
    always_comb begin
        w_index = '0;
        for (int unsigned b = 0; b < IDX_W; b++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i >> b) & 32'd1) != 32'd0) begin
                    w_index[b] = w_index[b] | w_one_hot[i];
                end
            end
        end
    end

    assign ack_mask = w_mask;

    if (USE_ONE_HOT != 0) begin : g_oh_on
        assign ack_one_hot = w_one_hot;
    end else begin : g_oh_off
        assign ack_one_hot = '0;
    end

    if (USE_COLD != 0) begin : g_cold_on
        assign cold_ack_mask = w_cold;
    end else begin : g_cold_off
        assign cold_ack_mask = '0;
    end

    if (USE_INDEX != 0) begin : g_idx_on
        assign ack_index = w_index;
    end else begin : g_idx_off
        assign ack_index = '0;
    end

    // Clock/reset exist for interface uniformity; intermediates may be dead when outputs are disabled.
    assign w_unused = ^{CLK, nRST, w_one_hot, w_cold, w_index};

endmodule

// File: tb/tb_pe_lsb.sv
// Scoreboard bench for pe_lsb: one shared random request stream drives ten configurations
// (default plus WIDTH 2/5/16 with each output disabled in turn) against a loop-based model.
module tb_pe_lsb;

    localparam int unsigned NDUT = 10;
    localparam int unsigned CW  [NDUT] = '{8, 2, 2, 2, 5, 5, 5, 16, 16, 16};
    localparam int unsigned COH [NDUT] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    localparam int unsigned CC  [NDUT] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    localparam int unsigned CI  [NDUT] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0};

    typedef struct packed {
        logic [15:0] oh;
        logic [15:0] mask;
        logic [15:0] cold;
        logic [3:0]  idx;
    } exp_t;

    typedef struct packed {
        logic [15:0]          req;
        exp_t [NDUT-1:0]      e;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;

    logic [15:0] act_oh   [NDUT];
    logic [15:0] act_mask [NDUT];
    logic [15:0] act_cold [NDUT];
    logic [3:0]  act_idx  [NDUT];

    entry_t q[$];
    int     checks = 0;
    int     errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < int'(NDUT); k++) begin : g_dut
        localparam int unsigned W  = CW[k];
        localparam int unsigned IW = $clog2(W);
        logic [W-1:0]  oh;
        logic [W-1:0]  mk;
        logic [W-1:0]  cd;
        logic [IW-1:0] ix;

        pe_lsb #(
            .WIDTH      (W),
            .USE_ONE_HOT(COH[k]),
            .USE_COLD   (CC[k]),
            .USE_INDEX  (CI[k])
        ) u_dut (
            .CLK          (clk),
            .nRST         (rst_n),
            .req_vec      (req[W-1:0]),
            .ack_one_hot  (oh),
            .ack_mask     (mk),
            .cold_ack_mask(cd),
            .ack_index    (ix)
        );

        assign act_oh[k]   = 16'(oh);
        assign act_mask[k] = 16'(mk);
        assign act_cold[k] = 16'(cd);
        assign act_idx[k]  = 4'(ix);
    end

    // Reference: find first set bit j, then build outputs directly from the definitions.
    function automatic exp_t ref_model(input logic [15:0] r, input int unsigned w,
                                       input int unsigned oh_en, input int unsigned c_en,
                                       input int unsigned i_en);
        exp_t e;
        int   j;
        e = '0;
        j = -1;
        for (int i = 0; i < int'(w); i++) begin
            if (r[i] && j < 0) j = i;
        end
        if (j >= 0) begin
            for (int i = 0; i < int'(w); i++) begin
                e.mask[i] = (i >= j);
                e.oh[i]   = (i == j) && (oh_en != 0);
                e.cold[i] = (i > j) && (c_en != 0);
            end
            e.idx = (i_en != 0) ? 4'(j) : 4'd0;
        end
        return e;
    endfunction

    task automatic drive(input logic [15:0] v, input logic rst_val);
        entry_t t;
        @(posedge clk);
        rst_n = rst_val;
        req   = v;
        t.req = v;
        for (int k = 0; k < int'(NDUT); k++) begin
            t.e[k] = ref_model(v, CW[k], COH[k], CC[k], CI[k]);
        end
        q.push_back(t);
    endtask

    task automatic chk(input string name, input int k, input logic [15:0] req_v,
                       input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL dut%0d(W=%0d) %s req=%h got %h want %h", k, CW[k], name, req_v, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so the DUT presents a result each negedge after a push.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            entry_t t;
            t = q.pop_front();
            for (int k = 0; k < int'(NDUT); k++) begin
                chk("ack_one_hot",   k, t.req, act_oh[k],          t.e[k].oh);
                chk("ack_mask",      k, t.req, act_mask[k],        t.e[k].mask);
                chk("cold_ack_mask", k, t.req, act_cold[k],        t.e[k].cold);
                chk("ack_index",     k, t.req, 16'(act_idx[k]),    16'(t.e[k].idx));
            end
        end
    end

    initial begin
        logic [15:0] r;
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);

        // Directed corners, zero under both reset levels.
        drive(16'h0000, 1'b0);
        drive(16'h0000, 1'b1);
        drive(16'h002C, 1'b1);
        drive(16'h00FF, 1'b1);
        drive(16'h0080, 1'b1);
        drive(16'h8000, 1'b1);
        drive(16'hFFFF, 1'b0);
        drive(16'h0010, 1'b1);

        // Exhaustive over the low 8 bits; upper bits random for the 16-wide instances.
        for (int v = 0; v < 256; v++) begin
            drive({8'($urandom), 8'(v)}, 1'b1);
        end

        // Random, shifted to spread the lowest set bit; nRST toggled at random.
        for (int n = 0; n < 300; n++) begin
            r = 16'($urandom) << $urandom_range(0, 15);
            drive(r, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_lsb.md
# pe_lsb

Parameterized LSB-first priority encoder. It takes a request vector and, combinationally, identifies the lowest-index asserted request. It reports that request as a one-hot grant, an inclusive upward mask, an exclusive ("cold") upward mask, and a binary index. It is a leaf utility used by schedulers, arbiters and free-list/queue allocators throughout the core.

## Interface
Parameters:
- WIDTH, default 8: number of request lines. Must be ≥ 2.
- USE_ONE_HOT, default 1: 1 = drive ack_one_hot; 0 = tie ack_one_hot to all zeros.
- USE_COLD, default 1: 1 = drive cold_ack_mask; 0 = tie cold_ack_mask to all zeros.
- USE_INDEX, default 1: 1 = drive ack_index; 0 = tie ack_index to zero.

Ports:
- CLK  input  1: clock. One clock domain. Functionally unused by the datapath; present for interface uniformity.
- nRST  input  1: asynchronous, active-low reset. Functionally unused by the datapath; outputs do not depend on it.
- req_vec  input  WIDTH: request vector. Bit i = request i.
- ack_one_hot  output  WIDTH: one-hot of the lowest set bit of req_vec.
- ack_mask  output  WIDTH: ones from the lowest set bit up to MSB, inclusive. Always driven, independent of the USE_* flags.
- cold_ack_mask  output  WIDTH: ones strictly above the lowest set bit up to MSB.
- ack_index  output  $clog2(WIDTH): binary index of the lowest set bit.

## Operation
- Let j = the smallest i with req_vec[i] = 1.
- If such a j exists:
  - ack_one_hot[i] = (i == j).
  - ack_mask[i] = (i ≥ j).
  - cold_ack_mask[i] = (i > j).
  - ack_index = j.
- If req_vec = 0: ack_one_hot = 0, ack_mask = 0, cold_ack_mask = 0, ack_index = 0. There is no separate valid output; the caller uses |req_vec or |ack_one_hot.
- Invariants when any request is set:
  - ack_mask = ack_one_hot | cold_ack_mask.
  - ack_one_hot & cold_ack_mask = 0.
  - ack_mask = req_vec | (~req_vec + 1) restricted to WIDTH bits; equivalently, all bits at and above the lowest set bit.
- Bit j = WIDTH-1 (MSB only): cold_ack_mask = 0, ack_mask = one-hot MSB, ack_index = WIDTH-1.
- Non-power-of-2 WIDTH: ack_index is still $clog2(WIDTH) bits; values ≥ WIDTH never occur.
- Disabled outputs (USE_* = 0) are constant zero. The logic feeding them is removable by synthesis.
- Implementation freedom:
  - Any structure is allowed (ripple prefix-OR, log-depth parallel prefix, or tree encoder for the index).
  - Preferred: log-depth parallel prefix-OR for the masks and an OR-tree encoder for ack_index, generated parametrically from WIDTH.
  - No latches, no X propagation for fully-known inputs.

## Timing
- Purely combinational: req_vec to all outputs, zero-cycle latency. No internal state, no handshake.
- Outputs must settle within half a clock period of a req_vec change.
- Reset value: during nRST = 0, outputs still follow req_vec combinationally. With req_vec = 0, all outputs are 0.
- Assertion or deassertion of nRST at any time has no effect on the outputs.
- No CLK edge is required for outputs to update.

## Test plan
- Zero: req_vec = 8'b00000000, under both nRST = 0 and nRST = 1 -> ack_one_hot = 0, ack_mask = 0, cold_ack_mask = 0, ack_index = 3'h0.
- Mid bit: req_vec = 8'b00101100 -> ack_one_hot = 00000100, ack_mask = 11111100, cold_ack_mask = 11111000, ack_index = 2.
- All ones: req_vec = 8'b11111111 -> ack_one_hot = 00000001, ack_mask = 11111111, cold_ack_mask = 11111110, ack_index = 0.
- MSB only: req_vec = 8'b10000000 -> ack_one_hot = 10000000, ack_mask = 10000000, cold_ack_mask = 00000000, ack_index = 7.
- Exhaustive: WIDTH = 8, all 256 req_vec values applied.
  - Apply each value after a posedge; check at the following negedge.
  - Compare all four outputs with `!==` against a loop-based reference model (first set bit j, masks as defined above).
  - Required result: zero mismatches.
- Parameter sweep: WIDTH ∈ {2, 5, 16} with each USE_* = 0 in turn -> the disabled output reads constant 0 for every input; the other outputs still match the reference model.
